// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multi_cycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               zero;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_source;
  logic [1:0]         alu_op;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, zero,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, state
  );

  modport slave (
    output opcode, zero,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal_op, state
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Moore-style controller for a multi-cycle MIPS subset (lw, sw, R-type, beq, addi, j).
// Outputs decode from the state register; pc_en additionally follows zero in BEQEX.
module multi_cycle_control #(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_cycle_control_if.master  bus
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(4'd0),
    DECODE = STATE_W'(4'd1),
    MEMADR = STATE_W'(4'd2),
    MEMRD  = STATE_W'(4'd3),
    MEMWB  = STATE_W'(4'd4),
    MEMWR  = STATE_W'(4'd5),
    RTEX   = STATE_W'(4'd6),
    RTWB   = STATE_W'(4'd7),
    BEQEX  = STATE_W'(4'd8),
    ADDIEX = STATE_W'(4'd9),
    ADDIWB = STATE_W'(4'd10),
    JEX    = STATE_W'(4'd11)
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        pc_en_s;
  logic        iord_s;
  logic        mem_read_s;
  logic        mem_write_s;
  logic        ir_write_s;
  logic        reg_dst_s;
  logic        mem_to_reg_s;
  logic        reg_write_s;
  logic        alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [1:0]  pc_source_s;
  logic [1:0]  alu_op_s;
  logic        illegal_op_s;

  // State register; reset overrides any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    next_state_s = FETCH;
    pc_en_s      = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    pc_source_s  = 2'b00;
    alu_op_s     = 2'b00;
    illegal_op_s = 1'b0;
    case (state_r)
      FETCH: begin
        mem_read_s   = 1'b1;
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b01;
        pc_en_s      = 1'b1;
        next_state_s = DECODE;
      end
      DECODE: begin
        alu_src_b_s = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = RTEX;
          OP_BEQ:       next_state_s = BEQEX;
          OP_ADDI:      next_state_s = ADDIEX;
          OP_J:         next_state_s = JEX;
          default: begin
            illegal_op_s = 1'b1;
            next_state_s = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (bus.opcode == OP_LW) begin
          next_state_s = MEMRD;
        end else begin
          next_state_s = MEMWR;
        end
      end
      MEMRD: begin
        iord_s       = 1'b1;
        mem_read_s   = 1'b1;
        next_state_s = MEMWB;
      end
      MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        next_state_s = FETCH;
      end
      MEMWR: begin
        iord_s       = 1'b1;
        mem_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      RTEX: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b10;
        next_state_s = RTWB;
      end
      RTWB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        next_state_s = FETCH;
      end
      BEQEX: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = 2'b01;
        pc_source_s  = 2'b01;
        pc_en_s      = bus.zero;
        next_state_s = FETCH;
      end
      ADDIEX: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        next_state_s = ADDIWB;
      end
      ADDIWB: begin
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      JEX: begin
        pc_source_s  = 2'b10;
        pc_en_s      = 1'b1;
        next_state_s = FETCH;
      end
      default: begin
        // Unused encodings stay silent and recover to FETCH.
        next_state_s = FETCH;
      end
    endcase
  end

  // Write strobes and the illegal flag are held low while reset is high.
  assign bus.pc_en      = pc_en_s & ~reset;
  assign bus.mem_read   = mem_read_s & ~reset;
  assign bus.mem_write  = mem_write_s & ~reset;
  assign bus.ir_write   = ir_write_s & ~reset;
  assign bus.reg_write  = reg_write_s & ~reset;
  assign bus.illegal_op = illegal_op_s & ~reset;
  assign bus.iord       = iord_s;
  assign bus.reg_dst    = reg_dst_s;
  assign bus.mem_to_reg = mem_to_reg_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.pc_source  = pc_source_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.state      = state_r;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter: STATE_W, default 4, width of the state register and the state debug output.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 opcode  input  6  instruction bits [31:26], from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 pc_en  output  1  PC register load enable.
REQ-007 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 mem_read, mem_write  output  1 each  memory read and memory write strobes.
REQ-009 ir_write  output  1  instruction register load enable.
REQ-010 reg_dst, mem_to_reg, reg_write  output  1 each  register-file write controls.
REQ-011 alu_src_a  output  1  ALU operand A select: 0 = PC, 1 = register A.
REQ-012 alu_src_b  output  2  Ctrl input of the ALU-B 4:1 mux: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
REQ-013 pc_source  output  2  Ctrl input of the PC 4:1 mux: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reserved.
REQ-014 alu_op  output  2  ALU operation class: 00 = add, 01 = sub, 10 = funct-decoded.
REQ-015 illegal_op  output  1  one-cycle flag raised for an unsupported opcode.
REQ-016 state  output  STATE_W  current state encoding, for debug.

Function
REQ-017 The block SHALL be a Moore FSM: a registered state, with all outputs decoded combinationally from the state; the only exception is pc_en, which also depends on zero.
REQ-018 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-019 Any output not listed for a state in REQ-020 to REQ-031 SHALL be 0 in that state.
REQ-020 FETCH: mem_read=1, ir_write=1, alu_src_b=01, pc_source=00, pc_en=1; next state DECODE.
REQ-021 DECODE: alu_src_b=11.
REQ-022 DECODE next state by opcode: 100011/101011 -> MEMADR; 000000 -> RTEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX.
REQ-023 DECODE with any other opcode: next state FETCH, and illegal_op=1 in that DECODE cycle.
REQ-024 MEMADR: alu_src_a=1, alu_src_b=10; next state MEMRD if opcode=100011, otherwise MEMWR.
REQ-025 MEMRD: iord=1, mem_read=1; next state MEMWB.
REQ-026 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state FETCH.
REQ-027 MEMWR: iord=1, mem_write=1; next state FETCH.
REQ-028 RTEX: alu_src_a=1, alu_src_b=00, alu_op=10; next state RTWB. RTWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
REQ-029 BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero; next state FETCH.
REQ-030 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
REQ-031 JEX: pc_source=10, pc_en=1; next state FETCH.
REQ-032 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-033 An unused state encoding (12-15) SHALL drive all outputs 0 and SHALL transition to FETCH on the next edge.
REQ-034 opcode SHALL be sampled only in DECODE and MEMADR; opcode changes in any other state SHALL have no effect.
REQ-035 At most one of mem_read and mem_write SHALL be high in any cycle, and reg_write and mem_write SHALL never be high together.

Reset
REQ-036 While reset is high, all write and strobe outputs (pc_en, ir_write, mem_read, mem_write, reg_write) and illegal_op SHALL be forced to 0, regardless of the current state.
REQ-037 While reset is high, the state register SHALL load FETCH (0) on each rising edge; reset takes priority over every transition, including an assertion in the middle of an instruction.
REQ-038 On the first cycle after reset is released, the block SHALL be in FETCH with pc_en=1 and ir_write=1.

Verification
REQ-039 Reset held 3 cycles, then lw (100011) -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-040 sw (101011) -> sequence 0,1,2,5,0; mem_write=1 and iord=1 only in state 5; reg_write=0 throughout.
REQ-041 beq (000100) with zero=1 -> pc_en=1 and pc_source=01 in state 8; repeat with zero=0 -> pc_en=0 in state 8.
REQ-042 R-type, then addi, then j -> alu_src_b = 01,11,00 / 01,11,10 / 01,11 per cycle; reg_dst=1 only in RTWB; pc_source=10 in JEX.
REQ-043 Opcode 111111 -> illegal_op=1 for exactly the one DECODE cycle; next state 0; no write strobes asserted.
REQ-044 Reset asserted in MEMRD -> next state 0 and all strobes 0 while reset is high; normal fetch on the first cycle after release.
